// File: rtl/imsic_msi_axil_receiver.sv
// AXI4-Lite write responder that turns MSI writes into set-pending requests for an IMSIC.
// Optional IMSIC_MSI_BIG_ENDIAN_EN also accepts seteipnum_be (page offset 0x004).
module imsic_msi_axil_receiver #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned NrFiles        = 4,
    parameter logic [AddrWidth-1:0] BaseAddr = 64'h2400_0000,
    parameter int unsigned FileStrideLog2 = 12,
    parameter int unsigned NrIntIds       = 64,
    localparam int unsigned FileW         = $clog2(NrFiles),
    localparam int unsigned EiidW         = $clog2(NrIntIds)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [AddrWidth-1:0]   i_awaddr,
    input  logic                   i_awvalid,
    output logic                   o_awready,
    input  logic [DataWidth-1:0]   i_wdata,
    input  logic [DataWidth/8-1:0] i_wstrb,
    input  logic                   i_wvalid,
    output logic                   o_wready,
    output logic [1:0]             o_bresp,
    output logic                   o_bvalid,
    input  logic                   i_bready,
    output logic                   o_msi_valid,
    output logic [FileW-1:0]       o_msi_file,
    output logic [EiidW-1:0]       o_msi_eiid,
    input  logic                   i_msi_ready,
    output logic                   o_busy
);

    typedef enum logic [1:0] {StIdle, StDispatch, StResp} state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    state_e                 state_q, state_d;
    logic                   aw_full_q, aw_full_d;
    logic                   w_full_q, w_full_d;
    logic [AddrWidth-1:0]   awaddr_q, awaddr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [DataWidth/8-1:0] wstrb_q, wstrb_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   msi_valid_q, msi_valid_d;
    logic [FileW-1:0]       msi_file_q, msi_file_d;
    logic [EiidW-1:0]       msi_eiid_q, msi_eiid_d;

    logic                      awready, wready;
    logic [AddrWidth-1:0]      addr_off, page_idx;
    logic [FileStrideLog2-1:0] page_off;
    logic                      dec_err, off_le, off_be, eiid_ok;
    logic [DataWidth-1:0]      eiid_data;

    // Address decode: subtract first so a low address cannot alias a valid page
    always_comb begin
        addr_off = awaddr_q - BaseAddr;
        page_idx = addr_off >> FileStrideLog2;
        page_off = addr_off[FileStrideLog2-1:0];
        dec_err  = (awaddr_q < BaseAddr) || (page_idx >= AddrWidth'(NrFiles));
        off_le   = (page_off == '0);
`ifdef IMSIC_MSI_BIG_ENDIAN_EN
        off_be   = (page_off == FileStrideLog2'(4));
        eiid_data = wdata_q;
        if (off_be) begin
            for (int i = 0; i < DataWidth / 8; i++) begin
                eiid_data[8*i +: 8] = wdata_q[DataWidth-8-8*i +: 8];
            end
        end
`else
        off_be    = 1'b0;
        eiid_data = wdata_q;
`endif
        eiid_ok = (eiid_data != '0) && (eiid_data < DataWidth'(NrIntIds));
    end

    assign awready = (state_q == StIdle) && !aw_full_q;
    assign wready  = (state_q == StIdle) && !w_full_q;

    always_comb begin
        state_d     = state_q;
        aw_full_d   = aw_full_q;
        w_full_d    = w_full_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        msi_valid_d = msi_valid_q;
        msi_file_d  = msi_file_q;
        msi_eiid_d  = msi_eiid_q;

        unique case (state_q)
            StIdle: begin
                if (i_awvalid && awready) begin
                    aw_full_d = 1'b1;
                    awaddr_d  = i_awaddr;
                end
                if (i_wvalid && wready) begin
                    w_full_d = 1'b1;
                    wdata_d  = i_wdata;
                    wstrb_d  = i_wstrb;
                end
                if (aw_full_q && w_full_q) begin
                    if (dec_err) begin
                        bresp_d  = RespDecErr;
                        bvalid_d = 1'b1;
                        state_d  = StResp;
                    end else if (!(&wstrb_q)) begin
                        bresp_d  = RespSlvErr;
                        bvalid_d = 1'b1;
                        state_d  = StResp;
                    end else if (!(off_le || off_be) || !eiid_ok) begin
                        // Reserved offsets and out-of-range identities are silently dropped
                        bresp_d  = RespOkay;
                        bvalid_d = 1'b1;
                        state_d  = StResp;
                    end else begin
                        msi_valid_d = 1'b1;
                        msi_file_d  = page_idx[FileW-1:0];
                        msi_eiid_d  = eiid_data[EiidW-1:0];
                        state_d     = StDispatch;
                    end
                end
            end
            StDispatch: begin
                if (i_msi_ready) begin
                    msi_valid_d = 1'b0;
                    bresp_d     = RespOkay;
                    bvalid_d    = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (i_bready) begin
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RespOkay;
            msi_valid_q <= 1'b0;
            msi_file_q  <= '0;
            msi_eiid_q  <= '0;
        end else begin
            state_q     <= state_d;
            aw_full_q   <= aw_full_d;
            w_full_q    <= w_full_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            msi_valid_q <= msi_valid_d;
            msi_file_q  <= msi_file_d;
            msi_eiid_q  <= msi_eiid_d;
        end
    end

    assign o_awready   = awready;
    assign o_wready    = wready;
    assign o_bvalid    = bvalid_q;
    assign o_bresp     = bresp_q;
    assign o_msi_valid = msi_valid_q;
    assign o_msi_file  = msi_file_q;
    assign o_msi_eiid  = msi_eiid_q;
    assign o_busy      = (state_q != StIdle) || aw_full_q || w_full_q;

endmodule

// File: tb/tb_imsic_msi_axil_receiver.sv
// Directed bench for imsic_msi_axil_receiver: expected msi requests and B responses are queued
// when a transaction is driven and checked as the DUT produces them.
module tb_imsic_msi_axil_receiver;

    logic        i_clk;
    logic        i_rst;
    logic [63:0] i_awaddr;
    logic        i_awvalid;
    logic        o_awready;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_wvalid;
    logic        o_wready;
    logic [1:0]  o_bresp;
    logic        o_bvalid;
    logic        i_bready;
    logic        o_msi_valid;
    logic [1:0]  o_msi_file;
    logic [5:0]  o_msi_eiid;
    logic        i_msi_ready;
    logic        o_busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] msi_q[$];
    logic [1:0] b_q[$];

    imsic_msi_axil_receiver dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_awaddr    (i_awaddr),
        .i_awvalid   (i_awvalid),
        .o_awready   (o_awready),
        .i_wdata     (i_wdata),
        .i_wstrb     (i_wstrb),
        .i_wvalid    (i_wvalid),
        .o_wready    (o_wready),
        .o_bresp     (o_bresp),
        .o_bvalid    (o_bvalid),
        .i_bready    (i_bready),
        .o_msi_valid (o_msi_valid),
        .o_msi_file  (o_msi_file),
        .o_msi_eiid  (o_msi_eiid),
        .i_msi_ready (i_msi_ready),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 64'({o_awready, o_wready, o_bvalid, o_bresp, o_msi_valid, o_msi_file,
                        o_msi_eiid, o_busy}),
              64'({1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 6'd0, 1'b0}));
    endtask

    // w_lead > 0: W leads AW by that many cycles; < 0: AW leads W
    task automatic run_txn(input string name, input logic [63:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int msi_hold,
                           input int b_hold, input bit exp_msi, input logic [1:0] exp_file,
                           input logic [5:0] exp_eiid, input logic [1:0] exp_bresp);
        int cyc = 0;
        int acc_cyc = -1;
        int hs_cyc = -1;
        int msi_wait = 0;
        int b_wait = 0;
        int aw_start = (w_lead > 0) ? w_lead : 0;
        int w_start = (w_lead < 0) ? -w_lead : 0;
        bit aw_done = 0;
        bit w_done = 0;
        bit b_done = 0;
        bit seen_out = 0;
        bit seen_b = 0;
        bit have_hold = 0;
        logic [7:0] hold_tgt = '0;
        logic [7:0] e;
        if (exp_msi) msi_q.push_back({exp_file, exp_eiid});
        b_q.push_back(exp_bresp);
        while (!b_done && cyc < 100) begin
            @(negedge i_clk);
            i_awaddr    = addr;
            i_wdata     = data;
            i_wstrb     = strb;
            i_awvalid   = !aw_done && (cyc >= aw_start);
            i_wvalid    = !w_done && (cyc >= w_start);
            i_msi_ready = o_msi_valid && (msi_wait >= msi_hold);
            i_bready    = o_bvalid && (b_wait >= b_hold);
            if (!seen_out && (o_msi_valid || o_bvalid)) begin
                seen_out = 1;
                check({name, " first-output latency"}, 64'(cyc), 64'(acc_cyc + 2));
            end
            if (o_msi_valid || o_bvalid)
                check({name, " stalled awready/wready/busy"},
                      64'({o_awready, o_wready, o_busy}), 64'(3'b001));
            if (o_msi_valid) begin
                if (!have_hold) begin
                    have_hold = 1;
                    hold_tgt = {o_msi_file, o_msi_eiid};
                end else begin
                    check({name, " msi target stable"}, 64'({o_msi_file, o_msi_eiid}),
                          64'(hold_tgt));
                end
                msi_wait++;
                if (i_msi_ready) begin
                    check({name, " msi request expected"}, 64'(msi_q.size() != 0), 64'(1));
                    if (msi_q.size() != 0) begin
                        e = msi_q.pop_front();
                        check({name, " msi file/eiid"}, 64'({o_msi_file, o_msi_eiid}), 64'(e));
                    end
                    hs_cyc = cyc;
                end
            end
            if (o_bvalid) begin
                if (!seen_b && exp_msi)
                    check({name, " bvalid after msi handshake"}, 64'(cyc), 64'(hs_cyc + 1));
                seen_b = 1;
                if (b_q.size() != 0) check({name, " bresp"}, 64'(o_bresp), 64'(b_q[0]));
                b_wait++;
                if (i_bready) begin
                    if (b_q.size() != 0) void'(b_q.pop_front());
                    b_done = 1;
                end
            end
            if (i_awvalid && o_awready) aw_done = 1;
            if (i_wvalid && o_wready) w_done = 1;
            if (aw_done && w_done && acc_cyc < 0) acc_cyc = cyc;
            cyc++;
        end
        check({name, " B handshake within budget"}, 64'(b_done), 64'(1));
        check({name, " expected msi requests consumed"}, 64'(msi_q.size()), 64'(0));
        @(negedge i_clk);
        i_awvalid   = 1'b0;
        i_wvalid    = 1'b0;
        i_msi_ready = 1'b0;
        i_bready    = 1'b0;
        check({name, " idle after B"}, 64'({o_awready, o_wready, o_bvalid, o_msi_valid, o_busy}),
              64'(5'b11000));
        msi_q.delete();
        b_q.delete();
    endtask

    initial begin
        bit seen;
        i_rst       = 1'b1;
        i_awaddr    = '0;
        i_awvalid   = 1'b0;
        i_wdata     = '0;
        i_wstrb     = '0;
        i_wvalid    = 1'b0;
        i_bready    = 1'b0;
        i_msi_ready = 1'b0;
        #1;
        check_reset_outputs("reset values");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("after reset release");

        run_txn("same-cycle file1", 64'h2400_1000, 32'h5, 4'hF, 0, 0, 0, 1, 2'd1, 6'd5, 2'b00);
        run_txn("w-first backpressure", 64'h2400_3000, 32'h9, 4'hF, 3, 4, 0, 1, 2'd3, 6'd9,
                2'b00);
        run_txn("page beyond NrFiles", 64'h2400_4000, 32'h5, 4'hF, 0, 0, 0, 0, 2'd0, 6'd0,
                2'b11);
        run_txn("below base", 64'h23FF_FFFC, 32'h5, 4'hF, 0, 0, 0, 0, 2'd0, 6'd0, 2'b11);
        run_txn("eiid zero", 64'h2400_0000, 32'h0, 4'hF, 0, 0, 0, 0, 2'd0, 6'd0, 2'b00);
        run_txn("eiid 64", 64'h2400_0000, 32'd64, 4'hF, 0, 0, 0, 0, 2'd0, 6'd0, 2'b00);
        run_txn("upper data bits", 64'h2400_0000, 32'h0001_0001, 4'hF, 0, 0, 0, 0, 2'd0, 6'd0,
                2'b00);
        run_txn("partial strobe", 64'h2400_0000, 32'h5, 4'h3, 0, 0, 0, 0, 2'd0, 6'd0, 2'b10);
        run_txn("reserved offset", 64'h2400_1008, 32'h5, 4'hF, 0, 0, 0, 0, 2'd0, 6'd0, 2'b00);
        run_txn("bready held low", 64'h2400_2000, 32'd63, 4'hF, 0, 0, 5, 1, 2'd2, 6'd63, 2'b00);
        run_txn("decerr bready low", 64'h2400_5000, 32'h5, 4'hF, -2, 0, 5, 0, 2'd0, 6'd0,
                2'b11);
        run_txn("aw-first file0", 64'h2400_0000, 32'h1, 4'hF, -2, 1, 1, 1, 2'd0, 6'd1, 2'b00);
`ifdef IMSIC_MSI_BIG_ENDIAN_EN
        run_txn("seteipnum_be", 64'h2400_2004, 32'h0700_0000, 4'hF, 0, 0, 0, 1, 2'd2, 6'd7,
                2'b00);
`else
        run_txn("seteipnum_be reserved", 64'h2400_2004, 32'h0700_0000, 4'hF, 0, 0, 0, 0, 2'd0,
                6'd0, 2'b00);
`endif

        // Reset while a request waits in DISPATCH
        @(negedge i_clk);
        i_awaddr  = 64'h2400_1000;
        i_wdata   = 32'h3;
        i_wstrb   = 4'hF;
        i_awvalid = 1'b1;
        i_wvalid  = 1'b1;
        @(negedge i_clk);
        i_awvalid = 1'b0;
        i_wvalid  = 1'b0;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge i_clk);
            seen = o_msi_valid;
        end
        check("reset test reached dispatch", 64'(seen), 64'(1));
        #2 i_rst = 1'b1;
        #1 check_reset_outputs("async reset mid-dispatch");
        @(negedge i_clk);
        i_rst       = 1'b0;
        i_msi_ready = 1'b1;
        i_bready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            check("no response after reset", 64'({o_bvalid, o_msi_valid, o_busy}), 64'(0));
        end
        i_msi_ready = 1'b0;
        i_bready    = 1'b0;

        run_txn("post-reset file3", 64'h2400_3000, 32'h2A, 4'hF, 1, 2, 2, 1, 2'd3, 6'd42, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imsic_msi_axil_receiver.md
Name: imsic_msi_axil_receiver

Overview:
- AXI4-Lite write responder at the IMSIC end of the MSI path.
- Accepts MSI writes from the AXI-lite write master or from the APLIC MSI channel.
- Decodes the target interrupt file and EIID from each write, then issues one handshaked set-pending request to the interrupt-file array.
- Returns the B response only after the request is consumed or rejected. One transaction is outstanding at a time.

Parameters:
- AddrWidth, 64, AXI address width.
- DataWidth, 32, AXI data width; wstrb is DataWidth/8 bits.
- NrFiles, 4, number of interrupt files, each occupying one page.
- BaseAddr, 64'h2400_0000, address of file 0.
- FileStrideLog2, 12, log2 of the page size in bytes (4 KiB).
- NrIntIds, 64, number of implemented interrupt identities.
- Derived localparams: FileW = $clog2(NrFiles), EiidW = $clog2(NrIntIds).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_awaddr  in  AddrWidth  write address.
- i_awvalid  in  1  write-address valid.
- o_awready  out  1  write-address ready.
- i_wdata  in  DataWidth  write data.
- i_wstrb  in  DataWidth/8  byte strobes.
- i_wvalid  in  1  write-data valid.
- o_wready  out  1  write-data ready.
- o_bresp  out  2  write response (00 OKAY, 10 SLVERR, 11 DECERR).
- o_bvalid  out  1  response valid.
- i_bready  in  1  response ready.
- o_msi_valid  out  1  set-pending request valid.
- o_msi_file  out  FileW  target interrupt file.
- o_msi_eiid  out  EiidW  identity to set pending.
- i_msi_ready  in  1  interrupt file accepts the request.
- o_busy  out  1  a transaction is in flight.

Behaviour:
- Reset values: o_awready=1, o_wready=1, o_bvalid=0, o_bresp=00, o_msi_valid=0, o_msi_file=0, o_msi_eiid=0, o_busy=0. Internal holding flags aw_full=0, w_full=0; state=IDLE.
- States: IDLE, DISPATCH, RESP.
- IDLE, capture:
  - AW and W are captured independently into holding registers. o_awready = IDLE && !aw_full; o_wready = IDLE && !w_full.
  - AW and W may arrive in either order or in the same cycle.
- IDLE, decode: in the first cycle where aw_full && w_full, decode and register the outputs and the next state.
  - Address below BaseAddr, or (awaddr-BaseAddr)>>FileStrideLog2 >= NrFiles -> bresp=11, go to RESP. No address wrap-around is permitted.
  - i_wstrb != all-ones -> bresp=10, go to RESP.
  - Page offset != 0x000 (seteipnum_le) -> bresp=00, go to RESP, write dropped. All other offsets are reserved.
  - EIID == 0 or EIID >= NrIntIds (including any nonzero upper data bits) -> bresp=00, go to RESP, write dropped.
  - Otherwise latch o_msi_file and o_msi_eiid, then go to DISPATCH.
- DISPATCH:
  - o_msi_valid=1; file and eiid are held stable until i_msi_ready=1.
  - On the handshake, in the same edge: o_msi_valid=0, bresp=00, go to RESP.
- RESP:
  - o_bvalid=1 and o_bresp are held until i_bready=1.
  - On the handshake: clear o_bvalid, aw_full and w_full; go to IDLE. o_awready and o_wready rise the next cycle.
- Latency:
  - AW and W both accepted at edge N -> o_msi_valid high from edge N+1.
  - msi handshake at edge M -> o_bvalid high from edge M.
  - Error and drop paths: o_bvalid high from edge N+1.
- o_busy = (state != IDLE) || aw_full || w_full.
- Simultaneous events:
  - AW and W in the same cycle are both accepted.
  - A new AW or W arriving during DISPATCH or RESP is stalled (ready=0).
- Reset asserted mid-transaction: all state and outputs return to reset values asynchronously. The pending request is discarded, and no B response or msi request is issued.

Optional Feature:
- Macro IMSIC_MSI_BIG_ENDIAN_EN.
- Defined: page offset 0x004 (seteipnum_be) is also accepted. wdata is byte-swapped before EIID decode; the rest of the decode is unchanged.
- Undefined: offset 0x004 is reserved and handled as OKAY with the write dropped.

Test Plan:
- AW 0x2400_1000 and W 32'h5 in the same cycle, i_msi_ready=1 -> o_msi_valid for one cycle with file=1, eiid=5; then bvalid with bresp=00.
- W 32'h9 three cycles before AW 0x2400_3000, i_msi_ready low for 4 cycles -> o_msi_valid held with file=3, eiid=9 stable; awready=wready=0 throughout; B follows the ready handshake.
- AW 0x2400_4000 (NrFiles=4) -> bresp=11, no o_msi_valid. AW 0x23FF_FFFC -> bresp=11.
- Valid page with W=0 -> bresp=00, no pulse. W=64 -> bresp=00, no pulse. wstrb=4'h3 -> bresp=10, no pulse.
- i_bready low for 5 cycles -> bvalid and bresp held, a new AW is stalled.
- i_rst pulsed while in DISPATCH -> all outputs at reset values next cycle, no B response issued.
- AW 0x2400_2004, W 32'h0700_0000:
  - with IMSIC_MSI_BIG_ENDIAN_EN -> file=2, eiid=7.
  - without -> bresp=00, no o_msi_valid.
